// File: rtl/sdp_read_streamer.sv
// sdp_read_streamer
//   Read-side controller for a simple dual-port RAM with a registered,
//   1-cycle-latency read port. A start command streams num_words words from
//   consecutive (wrapping) addresses onto a valid/ready output through a small
//   credit-controlled FIFO that absorbs the RAM latency and back-pressure.
// Ports
//   clk, reset          clock (posedge) and asynchronous active-high reset
//   start, start_addr,
//   num_words           burst command, sampled only in IDLE
//   busy, done          burst in progress / one-cycle completion pulse
//   rd_addr, rd_data    RAM read address out, RAM read data in
//   out_data, out_valid,
//   out_ready           output stream (transfer = out_valid & out_ready)
module sdp_read_streamer #(
  parameter int unsigned address_width = 9,
  parameter int unsigned word_length   = 40,
  parameter int unsigned len_width     = 10,
  parameter int unsigned fifo_depth    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [address_width-1:0] start_addr,
  input  logic [len_width-1:0]     num_words,
  output logic                     busy,
  output logic                     done,
  output logic [address_width-1:0] rd_addr,
  input  logic [word_length-1:0]   rd_data,
  output logic [word_length-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int unsigned PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  // Occupancy math needs headroom for count + inflight before a pop is removed.
  localparam int unsigned CW = $clog2(fifo_depth + 2);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [address_width-1:0] rd_addr_q, rd_addr_d;
  logic [len_width-1:0]     issue_left_q, issue_left_d;
  logic [len_width-1:0]     pop_left_q, pop_left_d;
  logic                     inflight_q, inflight_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [word_length-1:0]   fifo_mem_q [fifo_depth];

  logic          pop;
  logic          issue;
  logic [CW-1:0] occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(fifo_depth - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    pop   = (count_q != '0) && out_ready;
    // Occupancy once the in-flight word lands and this cycle's pop leaves;
    // issuing only below depth guarantees the capture always has a slot.
    occ   = count_q + CW'(inflight_q) - CW'(pop);
    issue = (state_q == READ) && (issue_left_q != '0) && (occ < CW'(fifo_depth));

    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    issue_left_d = issue_left_q;
    pop_left_d   = pop_left_q;
    inflight_d   = issue;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            state_d      = READ;
            rd_addr_d    = start_addr;
            issue_left_d = num_words;
            pop_left_d   = num_words;
          end else begin
            state_d = DONE;
          end
        end
      end
      READ: begin
        if (issue) begin
          rd_addr_d    = rd_addr_q + address_width'(1);
          issue_left_d = issue_left_q - len_width'(1);
        end
        if (pop) begin
          pop_left_d = pop_left_q - len_width'(1);
          if (pop_left_q == len_width'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == READ);
    done_d = (state_d == DONE);

    count_d  = occ;
    wr_ptr_d = inflight_q ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_addr_q    <= '0;
      issue_left_q <= '0;
      pop_left_q   <= '0;
      inflight_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int unsigned i = 0; i < fifo_depth; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_addr_q    <= rd_addr_d;
      issue_left_q <= issue_left_d;
      pop_left_q   <= pop_left_d;
      inflight_q   <= inflight_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      if (inflight_q) begin
        fifo_mem_q[wr_ptr_q] <= rd_data;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_addr   = rd_addr_q;
  assign out_valid = (count_q != '0);
  assign out_data  = fifo_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_sdp_read_streamer.sv
module tb_sdp_read_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  start_addr;
  logic [9:0]  num_words;
  logic        busy;
  logic        done;
  logic [8:0]  rd_addr;
  logic [39:0] rd_data;
  logic [39:0] out_data;
  logic        out_valid;
  logic        out_ready;

  logic [39:0] ram [512];
  logic [39:0] exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_xfer   = 0;

  logic        stalled = 1'b0;
  logic [39:0] stall_data = '0;

  always #5 clk = ~clk;

  sdp_read_streamer #(
    .address_width(9),
    .word_length  (40),
    .len_width    (10),
    .fifo_depth   (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .start_addr(start_addr),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // RAM model: registered read, one cycle latency
  always @(posedge clk) rd_data <= ram[rd_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(stall_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_xfer: got data %0d expected no transfer at %0t", out_data, $time);
        end else begin
          logic [39:0] e;
          e = exp_q.pop_front();
          check("stream_data", 64'(out_data), 64'(e));
        end
        n_xfer++;
      end
      stalled    = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  // Issues a start at edge E0 and returns 1ns into cycle 1.
  task automatic start_burst(input int addr, input int n);
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = 9'(addr);
    num_words  = 10'(n);
    for (int i = 0; i < n; i++) exp_q.push_back(ram[(addr + i) % 512]);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (c < 300) begin
      @(negedge clk);
      if (done) break;
      c++;
    end
    check("done_seen", 64'(done), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
  endtask

  task automatic check_drained(input int n);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("xfer_count", 64'(n_xfer), 64'(n));
  endtask

  initial begin
    logic [15:0] pat;
    pat = 16'b1011_0100_0110_1001;
    for (int i = 0; i < 512; i++) ram[i] = 40'(i + 100);
    reset = 1'b1; start = 1'b0; start_addr = '0; num_words = '0; out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    reset = 1'b0;

    // 1) base timing: valid cycles 3..6, done in cycle 7
    n_xfer = 0;
    start_burst(5, 4);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check($sformatf("t1_valid_c%0d", c), 64'(out_valid), 64'((c >= 3 && c <= 6) ? 1 : 0));
      check($sformatf("t1_done_c%0d", c), 64'(done), 64'((c == 7) ? 1 : 0));
      check($sformatf("t1_busy_c%0d", c), 64'(busy), 64'((c <= 6) ? 1 : 0));
      if (c == 1) check("t1_rd_addr_c1", 64'(rd_addr), 64'd5);
    end
    check_drained(4);

    // 2) address wrap 510,511,0,1
    n_xfer = 0;
    start_burst(510, 4);
    @(negedge clk);
    check("t2_rd_addr_c1", 64'(rd_addr), 64'd510);
    wait_done();
    check_drained(4);

    // 3) back-pressure pattern
    n_xfer = 0;
    start_burst(20, 8);
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          out_ready = pat[i % 16];
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
      wait_done();
    join
    check_drained(8);

    // 4) zero-length burst
    n_xfer = 0;
    start_burst(7, 0);
    @(negedge clk);
    check("t4_done_c1", 64'(done), 64'd1);
    check("t4_busy_c1", 64'(busy), 64'd0);
    check("t4_valid_c1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("t4_done_c2", 64'(done), 64'd0);
    check("t4_valid_c2", 64'(out_valid), 64'd0);
    check_drained(0);

    // 5) start while busy is ignored
    n_xfer = 0;
    start_burst(40, 6);
    start = 1'b1; start_addr = 9'd300; num_words = 10'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    check_drained(6);

    // 6) reset during word 3 of 6, then a fresh 2-word burst
    n_xfer = 0;
    start_burst(60, 6);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_rd_addr", 64'(rd_addr), 64'd0);
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_data", 64'(out_data), 64'd0);
    check("t6_pre_xfers", 64'(n_xfer), 64'd2);
    @(posedge clk); #1;
    reset = 1'b0;
    n_xfer = 0;
    start_burst(70, 2);
    wait_done();
    repeat (4) @(negedge clk);
    check_drained(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
